fb_regfile_mp: RTL and testbench

Parametrised multi-port integer register file with a per-register busy scoreboard, for the pipelined core's decode/writeback boundary. It generalises the single-write, two-read file to configurable data width, register count, read-port count and write-port count. Reads are registered on the rising edge with a fixed one-cycle latency, so no negedge sampling is needed. The scoreboard tracks in-flight destination registers so decode can stall on RAW hazards without external bookkeeping.

---
 rtl/fb_regfile_mp_pkg.sv | 26 ++
 rtl/fb_regfile_mp_sb.sv | 77 +++++++
 rtl/fb_regfile_mp.sv | 105 ++++++++++
 tb/tb_fb_regfile_mp.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_regfile_mp_pkg.sv
// -----------------------------------------------------------------------------
// fb_regfile_mp_pkg
// Shared definitions for the multi-port register file slice: the 32-bit
// width constant, default XLEN/NREG and the clog2 helper used to size
// address fields.
// Ports: none (package).
// -----------------------------------------------------------------------------
package fb_regfile_mp_pkg;

    localparam int FB_32BITS       = 32;
    localparam int FB_XLEN_DEFAULT = FB_32BITS;
    localparam int FB_NREG_DEFAULT = 32;

    // Smallest r with (1 << r) >= value; 0 for value <= 1.
    function automatic int fb_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fb_regfile_mp_sb.sv
// -----------------------------------------------------------------------------
// fb_regfile_sb
// Busy scoreboard for in-flight destination registers. A write on any port
// clears the busy bit of its address, an allocation sets one; a set and a
// clear of the same register in one cycle leave it busy. rbusy per read port
// captures the busy bit after this cycle's updates; sb_full is combinational
// from the current busy vector.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   raddr          NRD packed read addresses
//   we, waddr      NWR write enables / addresses (clear busy)
//   alloc_en/addr  set busy on allocation
//   rbusy          registered busy flag per read port
//   sb_full        every allocatable register is busy
// -----------------------------------------------------------------------------
module fb_regfile_sb
    import fb_regfile_mp_pkg::*;
#(
    parameter int NREG     = FB_NREG_DEFAULT,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = fb_clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NRD*AW-1:0] raddr,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] waddr,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    output logic [NRD-1:0]    rbusy,
    output logic              sb_full
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    // Clears first, then the set, so a same-cycle set wins.
    always_comb begin
        busy_next = busy;
        for (int k = 0; k < NWR; k++) begin
            if (we[k]) begin
                busy_next[waddr[k*AW +: AW]] = 1'b0;
            end
        end
        if (alloc_en) begin
            busy_next[alloc_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy  <= '0;
            rbusy <= '0;
        end else begin
            busy <= busy_next;
            for (int j = 0; j < NRD; j++) begin
                rbusy[j] <= busy_next[raddr[j*AW +: AW]];
            end
        end
    end

    // Register 0 is excluded from the full check when it is hardwired.
    always_comb begin
        sb_full = 1'b1;
        for (int i = 0; i < NREG; i++) begin
            if (!((ZERO_REG != 0) && (i == 0))) begin
                sb_full = sb_full & busy[i];
            end
        end
    end

endmodule

// File: rtl/fb_regfile_mp.sv
// -----------------------------------------------------------------------------
// fb_regfile_mp
// Parametrised multi-port integer register file with a busy scoreboard.
// Reads are registered with one cycle of latency. Writes from several ports
// land on the same edge; on an address collision the highest port wins.
// Optional build macro FB_REGFILE_BYPASS_EN: a same-edge read of a written
// address returns the new write data (write-first). Without it the read
// returns the pre-write array value (read-first).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   raddr / rdata         NRD packed read addresses / registered read data
//   rbusy                 registered busy flag per read port
//   we / waddr / wdata    NWR packed write ports
//   alloc_en / alloc_addr mark a destination register busy
//   sb_full               combinational, all allocatable registers busy
// -----------------------------------------------------------------------------
module fb_regfile_mp
    import fb_regfile_mp_pkg::*;
#(
    parameter int XLEN     = FB_XLEN_DEFAULT,
    parameter int NREG     = FB_NREG_DEFAULT,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = fb_clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    output logic                sb_full
);

    logic [XLEN-1:0] mem [NREG];
    logic [XLEN-1:0] rd_val [NRD];

    // Later loop iterations overwrite earlier ones, giving the highest port
    // priority on a shared address.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (we[k] && !((ZERO_REG != 0) && (waddr[k*AW +: AW] == '0))) begin
                    mem[waddr[k*AW +: AW]] <= wdata[k*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NRD; j++) begin
            rd_val[j] = mem[raddr[j*AW +: AW]];
`ifdef FB_REGFILE_BYPASS_EN
            for (int k = 0; k < NWR; k++) begin
                if (we[k] && (waddr[k*AW +: AW] == raddr[j*AW +: AW])) begin
                    rd_val[j] = wdata[k*XLEN +: XLEN];
                end
            end
`else
            // Read-first: the array value before this edge's writes.
`endif
            if ((ZERO_REG != 0) && (raddr[j*AW +: AW] == '0)) begin
                rd_val[j] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            for (int j = 0; j < NRD; j++) begin
                rdata[j*XLEN +: XLEN] <= rd_val[j];
            end
        end
    end

    fb_regfile_sb #(
        .NREG     (NREG),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .raddr      (raddr),
        .we         (we),
        .waddr      (waddr),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .rbusy      (rbusy),
        .sb_full    (sb_full)
    );

endmodule

// File: tb/tb_fb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_fb_regfile_mp
// Bench for fb_regfile_mp (default parameters). A behavioural model of the
// architectural registers and busy bits predicts rdata/rbusy/sb_full every
// cycle; directed steps pin known literal values, then random traffic runs.
// Follows FB_REGFILE_BYPASS_EN the same way as the design build.
// -----------------------------------------------------------------------------
module tb_fb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic [NWR-1:0]      we_v;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic                alloc_v;
    logic [AW-1:0]       alloc_a;
    logic                sb_full;

    logic [AW-1:0]   ra [NRD];
    logic [AW-1:0]   wa [NWR];
    logic [XLEN-1:0] wd [NWR];

    always_comb begin
        for (int j = 0; j < NRD; j++) raddr[j*AW +: AW] = ra[j];
        for (int k = 0; k < NWR; k++) begin
            waddr[k*AW +: AW]   = wa[k];
            wdata[k*XLEN +: XLEN] = wd[k];
        end
    end

    fb_regfile_mp #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raddr      (raddr),
        .rdata      (rdata),
        .rbusy      (rbusy),
        .we         (we_v),
        .waddr      (waddr),
        .wdata      (wdata),
        .alloc_en   (alloc_v),
        .alloc_addr (alloc_a),
        .sb_full    (sb_full)
    );

    // ---------------- scoreboard counters ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;
    logic check_en = 1'b0;

    task automatic chk(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [XLEN-1:0] m_reg  [NREG];
    logic            m_busy [NREG];
    logic [XLEN-1:0] exp_rdata [NRD];
    logic            exp_rbusy [NRD];
    logic [XLEN-1:0] m_v;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                m_reg[i]  = '0;
                m_busy[i] = 1'b0;
            end
            for (int j = 0; j < NRD; j++) begin
                exp_rdata[j] = '0;
                exp_rbusy[j] = 1'b0;
            end
        end else begin
            for (int j = 0; j < NRD; j++) begin
                m_v = m_reg[ra[j]];
`ifdef FB_REGFILE_BYPASS_EN
                for (int k = 0; k < NWR; k++)
                    if (we_v[k] && wa[k] == ra[j]) m_v = wd[k];
`endif
                if (ra[j] == 0) m_v = '0;
                exp_rdata[j] = m_v;
            end
            for (int k = 0; k < NWR; k++)
                if (we_v[k] && wa[k] != 0) m_reg[wa[k]] = wd[k];
            for (int k = 0; k < NWR; k++)
                if (we_v[k]) m_busy[wa[k]] = 1'b0;
            if (alloc_v && alloc_a != 0) m_busy[alloc_a] = 1'b1;
            for (int j = 0; j < NRD; j++) exp_rbusy[j] = m_busy[ra[j]];
        end
    end

    function automatic logic model_full();
        int n;
        n = 0;
        for (int i = 1; i < NREG; i++) if (m_busy[i]) n++;
        return (n == NREG - 1);
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (check_en) begin
            for (int j = 0; j < NRD; j++) begin
                chk("rdata", rdata[j*XLEN +: XLEN], exp_rdata[j]);
                chk("rbusy", XLEN'(rbusy[j]), XLEN'(exp_rbusy[j]));
            end
            chk("sb_full", XLEN'(sb_full), XLEN'(model_full()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        we_v    = '0;
        alloc_v = 1'b0;
        for (int k = 0; k < NWR; k++) begin
            wa[k] = '0;
            wd[k] = '0;
        end
        alloc_a = '0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        idle();
        for (int j = 0; j < NRD; j++) ra[j] = '0;
        reset = 1'b1;
        step();
        step();
        check_en = 1'b1;
        reset = 1'b0;

        // Reset state over every address.
        for (int a = 0; a < NREG; a++) begin
            ra[0] = AW'(a);
            ra[1] = AW'(NREG - 1 - a);
            step();
            chk("lit_reset_rdata", rdata[0 +: XLEN], '0);
            chk("lit_reset_rbusy", XLEN'(rbusy), '0);
        end
        chk("lit_reset_full", XLEN'(sb_full), '0);

        // Write x5 with a same-edge read.
        we_v[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF; ra[0] = 5'd5;
        step();
`ifdef FB_REGFILE_BYPASS_EN
        chk("lit_sameedge_x5", rdata[0 +: XLEN], 32'hDEADBEEF);
`else
        chk("lit_sameedge_x5", rdata[0 +: XLEN], 32'h0);
`endif
        idle();
        step();
        chk("lit_read_x5", rdata[0 +: XLEN], 32'hDEADBEEF);

        // Two ports to x7: port 1 wins.
        we_v = 2'b11; wa[0] = 5'd7; wa[1] = 5'd7; wd[0] = 32'h11; wd[1] = 32'h22;
        ra[0] = 5'd0;
        step();
        idle();
        ra[1] = 5'd7;
        step();
        chk("lit_priority_x7", rdata[XLEN +: XLEN], 32'h22);

        // Register zero ignores writes and allocations.
        we_v[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'h1234;
        step();
        idle();
        ra[0] = 5'd0; alloc_v = 1'b1; alloc_a = 5'd0;
        step();
        chk("lit_zero_rdata", rdata[0 +: XLEN], '0);
        chk("lit_zero_rbusy", XLEN'(rbusy[0]), '0);

        // Set beats clear on x3.
        idle();
        alloc_v = 1'b1; alloc_a = 5'd3; ra[0] = 5'd3;
        step();
        we_v[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'hA5;
        step();
        chk("lit_setwins_x3", XLEN'(rbusy[0]), 32'd1);

        // Fill the scoreboard, then release one entry.
        idle();
        for (int a = 1; a < NREG; a++) begin
            alloc_v = 1'b1; alloc_a = AW'(a);
            step();
        end
        chk("lit_full_set", XLEN'(sb_full), 32'd1);
        idle();
        we_v[0] = 1'b1; wa[0] = 5'd10; wd[0] = 32'h10;
        step();
        chk("lit_full_clear", XLEN'(sb_full), '0);

        // Reset discards writes and allocations in flight.
        idle();
        alloc_v = 1'b1; alloc_a = 5'd9; we_v[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'h55;
        step();
        reset = 1'b1; wd[0] = 32'h77;
        step();
        reset = 1'b0;
        idle();
        ra[0] = 5'd9; ra[1] = 5'd3;
        step();
        chk("lit_rst_rdata9", rdata[0 +: XLEN], '0);
        chk("lit_rst_rbusy", XLEN'(rbusy), '0);
        chk("lit_rst_full", XLEN'(sb_full), '0);

        // Random traffic, with an occasional reset.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int j = 0; j < NRD; j++) ra[j] = AW'($urandom_range(0, NREG - 1));
            for (int k = 0; k < NWR; k++) begin
                we_v[k] = ($urandom_range(0, 2) == 0);
                wa[k]   = AW'($urandom_range(0, NREG - 1));
                wd[k]   = $urandom;
            end
            alloc_v = ($urandom_range(0, 1) == 1);
            alloc_a = AW'($urandom_range(0, NREG - 1));
            step();
        end
        reset = 1'b0;
        idle();
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
